// File: rtl/blink_gen_pkg.sv
// blink_gen_pkg: shared definitions for the blink/pulse generator.
//   mode_t  - per-channel operating mode encoding (matches cfg_mode)
//   CH_MAX  - upper bound on the channel count
package blink_gen_pkg;

   localparam int CH_MAX = 16;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PULSE = 2'b11
   } mode_t;

endpackage

// File: rtl/blink_gen_tick_div.sv
// tick_div: free-running prescaler producing a registered 1-cycle tick
// every DIV clocks. Reusable on its own.
//   clk  - clock
//   res  - asynchronous active-high reset
//   clr  - synchronous phase clear (counter and pending tick)
//   tick - 1-cycle pulse, first one DIV clocks after reset/clear
module tick_div #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic res,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == CW'(DIV - 1));

   // tick is registered off the wrap compare, so it lands one cycle after
   // cnt==DIV-1, i.e. exactly DIV clocks after reset or clear.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= wrap;
         cnt  <= wrap ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/blink_gen.sv
// blink_gen: multi-channel programmable blink/pulse generator.
// A shared prescaler ticks at TICK_HZ; each channel counts ticks and drives
// its output according to its mode (OFF, ON, BLINK, PULSE).
//   clk        - clock
//   res        - asynchronous active-high reset
//   cfg_we     - 1-cycle config write strobe
//   cfg_ch     - target channel (out-of-range values are ignored)
//   cfg_mode   - 00 OFF, 01 ON, 10 BLINK, 11 PULSE
//   cfg_half   - half-period / pulse length in ticks (0 behaves as 1)
//   resync     - 1-cycle pulse, phase-aligns prescaler and all channels
//   tick       - prescaler tick
//   opt        - channel outputs
//   pulse_done - 1-cycle flag when a PULSE channel expires
module blink_gen
   import blink_gen_pkg::*;
#(
   parameter int CLK_HZ   = 50_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int CH       = 4,
   parameter int CNT_W    = 16,
   parameter int DEF_HALF = 500,
   localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk,
   input  logic             res,
   input  logic             cfg_we,
   input  logic [CHW-1:0]   cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [CNT_W-1:0] cfg_half,
   input  logic             resync,
   output logic             tick,
   output logic [CH-1:0]    opt,
   output logic [CH-1:0]    pulse_done
);

   localparam int DIV = CLK_HZ / TICK_HZ;

   if (DIV < 2) begin : g_div_chk
      $error("blink_gen: CLK_HZ/TICK_HZ must be at least 2");
   end
   if (CH < 1 || CH > CH_MAX) begin : g_ch_chk
      $error("blink_gen: CH must be in 1..16");
   end

   tick_div #(.DIV(DIV)) u_div (
      .clk  (clk),
      .res  (res),
      .clr  (resync),
      .tick (tick)
   );

   for (genvar i = 0; i < CH; i++) begin : g_ch
      mode_t            mode;
      logic [CNT_W-1:0] half;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] half_eff;
      logic             last;
      logic             wr;
      logic             opt_q;
      logic             done_q;

      assign half_eff = (half == '0) ? CNT_W'(1) : half;
      assign last     = (cnt == half_eff - CNT_W'(1));
      // Exact match against i<CH, so out-of-range cfg_ch never hits a channel.
      assign wr       = cfg_we && (cfg_ch == CHW'(i));

      // Priority: write, then resync, then tick. A write on a tick clock
      // swallows that tick, so no toggle or pulse_done can come from it.
      always_ff @(posedge clk or posedge res) begin
         if (res) begin
            mode   <= MODE_BLINK;
            half   <= CNT_W'(DEF_HALF);
            cnt    <= '0;
            opt_q  <= 1'b1;
            done_q <= 1'b0;
         end else begin
            done_q <= 1'b0;
            if (wr) begin
               mode  <= mode_t'(cfg_mode);
               half  <= cfg_half;
               cnt   <= '0;
               opt_q <= (cfg_mode != MODE_OFF);
            end else if (resync) begin
               cnt <= '0;
               if (mode == MODE_BLINK || mode == MODE_PULSE)
                  opt_q <= 1'b1;
            end else if (tick) begin
               case (mode)
                  MODE_BLINK: begin
                     if (last) begin
                        opt_q <= ~opt_q;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
                  MODE_PULSE: begin
                     if (last) begin
                        opt_q  <= 1'b0;
                        mode   <= MODE_OFF;
                        done_q <= 1'b1;
                        cnt    <= '0;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
                  default: cnt <= '0;
               endcase
            end
         end
      end

      assign opt[i]        = opt_q;
      assign pulse_done[i] = done_q;
   end

endmodule

// File: tb/tb_blink_gen.sv
// tb_blink_gen: directed bench with an output-change scoreboard.
// Stimulus pushes the expected {cycle, opt, pulse_done} of every output
// change; a monitor pops one entry per observed change and also checks
// tick against the expected prescaler phase each cycle.
module tb_blink_gen;
   import blink_gen_pkg::*;

   localparam int DIV = 10;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       cfg_we = 1'b0, resync = 1'b0;
   logic [1:0] cfg_ch = '0, cfg_mode = '0;
   logic [7:0] cfg_half = '0;
   logic       tick;
   logic [3:0] opt, pulse_done;

   // second instance with CH=3 for the out-of-range channel write
   logic       cfg_we2 = 1'b0;
   logic [1:0] cfg_ch2 = '0, cfg_mode2 = '0;
   logic [7:0] cfg_half2 = '0;
   logic       tick2;
   logic [2:0] opt2, pd2;

   blink_gen #(.CLK_HZ(1000), .TICK_HZ(100), .CH(4), .CNT_W(8), .DEF_HALF(3)) dut (
      .clk(clk), .res(res), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_half(cfg_half), .resync(resync), .tick(tick), .opt(opt), .pulse_done(pulse_done)
   );

   blink_gen #(.CLK_HZ(1000), .TICK_HZ(100), .CH(3), .CNT_W(8), .DEF_HALF(3)) dut3 (
      .clk(clk), .res(res), .cfg_we(cfg_we2), .cfg_ch(cfg_ch2), .cfg_mode(cfg_mode2),
      .cfg_half(cfg_half2), .resync(1'b0), .tick(tick2), .opt(opt2), .pulse_done(pd2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int anchor = 0;
   int checks = 0, failures = 0;
   logic mon_en = 1'b0;

   typedef struct {
      int         cyc;
      logic [3:0] opt;
      logic [3:0] pd;
   } ev_t;
   ev_t sb[$];

   always @(posedge clk or posedge res)
      if (res) cyc <= 0;
      else     cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [3:0] o, input logic [3:0] p);
      ev_t e;
      e.cyc = c; e.opt = o; e.pd = p;
      sb.push_back(e);
   endtask

   task automatic at_cyc(input int n);
      int g = 0;
      while (cyc != n && g < 2000) begin
         @(negedge clk);
         g++;
      end
      if (cyc != n) begin
         checks++; failures++;
         $display("FAIL at_cyc timeout: got cyc %0d want %0d", cyc, n);
      end
   endtask

   task automatic wr(input int at, input logic [1:0] ch, input logic [1:0] m, input logic [7:0] h);
      at_cyc(at);
      cfg_ch = ch; cfg_mode = m; cfg_half = h; cfg_we = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // monitor
   initial begin
      logic [3:0] po, pp;
      logic       et;
      ev_t        e;
      po = 4'b1111; pp = 4'b0000;
      wait (mon_en);
      forever begin
         @(negedge clk);
         et = (cyc > anchor) && (((cyc - anchor) % DIV) == 0);
         chk("tick", {31'd0, tick}, {31'd0, et});
         if (opt !== po || pulse_done !== pp) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_change: got opt=%b pd=%b at cyc %0d want no change", opt, pulse_done, cyc);
            end else begin
               e = sb.pop_front();
               chk("ev_cyc", cyc, e.cyc);
               chk("ev_opt", {28'd0, opt}, {28'd0, e.opt});
               chk("ev_pd", {28'd0, pulse_done}, {28'd0, e.pd});
            end
            po = opt; pp = pulse_done;
         end
      end
   end

   // stimulus
   initial begin
      #1 res = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("rst_opt", {28'd0, opt}, 32'hF);
      chk("rst_pd", {28'd0, pulse_done}, 32'h0);
      chk("rst_tick", {31'd0, tick}, 32'h0);
      mon_en = 1'b1;
      res = 1'b0;

      // default blink: half=3 ticks, ticks land on edges 10k+1
      push(31, 4'b0000, 4'b0000);
      push(61, 4'b1111, 4'b0000);
      // ch1 half0 toggles every tick, ch2 pulse 5 ticks, ch0 write on a tick
      push(71,  4'b1101, 4'b0000);
      push(81,  4'b1111, 4'b0000);
      push(91,  4'b1101, 4'b0000);
      push(101, 4'b1111, 4'b0000);
      push(111, 4'b1001, 4'b0100);
      push(112, 4'b1001, 4'b0000);
      push(121, 4'b1010, 4'b0000);
      push(131, 4'b1000, 4'b0000);
      push(141, 4'b1010, 4'b0000);
      // ch2 rewritten out of phase, then resync aligns ch0/ch2
      push(143, 4'b1110, 4'b0000);
      push(146, 4'b1111, 4'b0000);
      push(157, 4'b1101, 4'b0000);
      push(167, 4'b1111, 4'b0000);
      push(177, 4'b1000, 4'b0000);
      push(187, 4'b1010, 4'b0000);
      push(197, 4'b1000, 4'b0000);
      push(207, 4'b1111, 4'b0000);
      push(217, 4'b1101, 4'b0000);

      // out-of-range write on the CH=3 instance, then an in-range one
      at_cyc(5);
      cfg_ch2 = 2'd3; cfg_mode2 = MODE_OFF; cfg_half2 = 8'd1; cfg_we2 = 1'b1;
      @(negedge clk);
      cfg_we2 = 1'b0;
      @(negedge clk);
      chk("oor_opt", {29'd0, opt2}, 32'h7);
      cfg_ch2 = 2'd2; cfg_we2 = 1'b1;
      @(negedge clk);
      cfg_we2 = 1'b0;
      chk("inr_opt", {29'd0, opt2}, 32'h3);

      wr(65, 2'd2, MODE_PULSE, 8'd5);
      wr(66, 2'd1, MODE_BLINK, 8'd0);
      wr(67, 2'd3, MODE_ON,    8'd1);
      wr(90, 2'd0, MODE_BLINK, 8'd3);   // sampled on the tick-9 edge, cnt==2
      wr(142, 2'd2, MODE_BLINK, 8'd3);

      at_cyc(145);
      anchor = 146;
      resync = 1'b1;
      @(negedge clk);
      resync = 1'b0;

      wr(210, 2'd2, MODE_PULSE, 8'd5);

      // async reset mid-pulse, while ch1 is low
      at_cyc(220);
      push(0, 4'b1111, 4'b0000);
      #2 res = 1'b1;
      anchor = 0;
      #1;
      chk("ares_opt", {28'd0, opt}, 32'hF);
      chk("ares_pd", {28'd0, pulse_done}, 32'h0);
      @(negedge clk); @(negedge clk);
      res = 1'b0;
      push(31, 4'b0000, 4'b0000);
      push(61, 4'b1111, 4'b0000);
      at_cyc(65);

      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
